// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a single-entry
// output register with ready/valid handshake, frame-error and overrun pulses.
module uart_rx #(
  parameter int clk_freq = 10000000,
  parameter int baudrate = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int clks_per_bit = clk_freq / baudrate;
  localparam int half_bit     = clks_per_bit / 2;
  localparam logic [15:0] BIT_END  = 16'(clks_per_bit - 1);
  localparam logic [15:0] HALF_END = 16'(half_bit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [1:0]  sync_q;
  logic        rx_s;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        armed_q, armed_d;
  logic        done, ferr;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, ov_q, ov_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= ferr;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    armed_d = armed_q;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // A start edge only counts after the line has been seen high, so a
        // stuck-low line after a framing error never retriggers.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          done    = rx_s;
          ferr    = ~rx_s;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a completion may replace a byte only when it is being
  // consumed in the same cycle; otherwise the new byte is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, expected bytes queued
// by the stimulus and popped by a monitor on every rx_valid & rx_ready.
module tb_uart_rx;

  localparam int CPB = 86;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int vecs = 0;
  int errs = 0;
  int valid_cycles = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] sb[$];

  uart_rx #(.clk_freq(10000000), .baudrate(115200)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(logic [7:0] b, logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      wait_clks(CPB);
    end
    rx_in = 1'b1;
  endtask

  // Monitor / scoreboard
  logic       v_prev = 1'b0, r_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] d_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && fe_prev) chk("frame_err_width", 2, 1);
      if (overrun && ov_prev) chk("overrun_width", 2, 1);
      if (v_prev && !r_prev && rx_valid && rx_data != d_prev)
        chk("rx_data_stable", rx_data, d_prev);
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) chk("unexpected_byte", rx_data, -1);
        else chk("rx_data", rx_data, sb.pop_front());
      end
    end
    v_prev  = rx_valid && rst_n;
    r_prev  = rx_ready;
    d_prev  = rx_data;
    fe_prev = frame_err && rst_n;
    ov_prev = overrun && rst_n;
  end

  int v0, f0, o0;
  task automatic snap();
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
  endtask

  initial begin
    // reset state
    wait_clks(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    wait_clks(200);

    // clean 0x55 frame
    snap();
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_clks(100);
    chk("t55_valid_cycles", valid_cycles - v0, 1);
    chk("t55_frame_err", fe_cnt - f0, 0);
    chk("t55_overrun", ov_cnt - o0, 0);

    // false start, then 0xA3
    snap();
    rx_in = 1'b0;
    wait_clks(20);
    rx_in = 1'b1;
    wait_clks(200);
    chk("false_start_valid", valid_cycles - v0, 0);
    chk("false_start_ferr", fe_cnt - f0, 0);
    sb.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    wait_clks(100);
    chk("tA3_valid_cycles", valid_cycles - v0, 1);

    // framing error, line held low
    snap();
    send_frame(8'h7E, 1'b0);
    rx_in = 1'b0;
    wait_clks(1000);
    chk("ferr_pulses", fe_cnt - f0, 1);
    chk("ferr_valid", valid_cycles - v0, 0);
    rx_in = 1'b1;
    wait_clks(200);
    chk("ferr_no_retrigger", fe_cnt - f0, 1);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_clks(100);
    chk("recover_valid_cycles", valid_cycles - v0, 1);

    // back-to-back with consumer stalled: second byte lost
    snap();
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(100);
    chk("ovr_pulses", ov_cnt - o0, 1);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_rx_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(2);
    chk("ovr_valid_cleared", rx_valid, 0);

    // ready pulsed exactly on the completion cycle of the second byte
    snap();
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        #1;
        wait_clks(819);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
      end
    join
    wait_clks(100);
    chk("swap_overrun", ov_cnt - o0, 0);
    chk("swap_rx_valid", rx_valid, 1);
    chk("swap_rx_data", rx_data, 8'h22);
    rx_ready = 1'b1;
    wait_clks(3);
    chk("swap_valid_cleared", rx_valid, 0);

    // reset during bit 4 of 0xC3, released while the line is high
    snap();
    fork
      send_frame(8'hC3, 1'b1);
      begin
        @(posedge clk);
        #1;
        wait_clks(473);
        rst_n = 1'b0;
        #1;
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_overrun", overrun, 0);
        wait_clks(167);
        rst_n = 1'b1;
      end
    join
    wait_clks(200);
    chk("midrst_no_output", valid_cycles - v0, 0);
    chk("midrst_no_ferr", fe_cnt - f0, 0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_clks(100);
    chk("t3C_valid_cycles", valid_cycles - v0, 1);
    chk("t3C_overrun", ov_cnt - o0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    errs++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
